// File: rtl/router_pkg.sv
// router_pkg: state encoding, default sizes and address check shared by the router input controller
package router_pkg;

  localparam int DEF_NUM_PORTS = 3;
  localparam int DEF_ADDR_W    = 2;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  function automatic logic is_valid_addr(input int addr, input int num_ports);
    return addr < num_ports;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller steering header/payload/parity loads into the router register
module router_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 write_enb_reg,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 busy
);

  state_t              state, nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic                hdr_ok, hdr_empty, addr_empty, sr_hit;

  // Invalid indices read as 0 so an out-of-range address can never select a flag
  assign hdr_ok     = is_valid_addr(int'(data_in), NUM_PORTS);
  assign hdr_empty  = hdr_ok && fifo_empty[data_in];
  assign addr_empty = is_valid_addr(int'(addr_q), NUM_PORTS) && fifo_empty[addr_q];
  assign sr_hit     = is_valid_addr(int'(addr_q), NUM_PORTS) && soft_reset[addr_q];

  // Next-state selection; reset and destination soft reset both return to address decode
  always_comb begin
    nxt = DECODE_ADDRESS;
    case (state)
      DECODE_ADDRESS:     nxt = (pkt_valid && hdr_ok) ? (hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY) : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    nxt = addr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    nxt = LOAD_DATA;
      LOAD_DATA:          nxt = fifo_full ? FIFO_FULL_STATE : (!pkt_valid ? LOAD_PARITY : LOAD_DATA);
      FIFO_FULL_STATE:    nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    nxt = parity_done ? DECODE_ADDRESS : (low_pkt_valid ? LOAD_PARITY : LOAD_DATA);
      LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            nxt = DECODE_ADDRESS;
    endcase
    if (state != DECODE_ADDRESS && sr_hit) nxt = DECODE_ADDRESS;
    if (reset) nxt = DECODE_ADDRESS;
  end

  // State register with outputs registered from the next state, so each output is a pure decode of state
  always_ff @(posedge clk) begin
    state         <= nxt;
    detect_add    <= nxt == DECODE_ADDRESS;
    lfd_state     <= nxt == LOAD_FIRST_DATA;
    ld_state      <= nxt == LOAD_DATA;
    laf_state     <= nxt == LOAD_AFTER_FULL;
    full_state    <= nxt == FIFO_FULL_STATE;
    rst_int_reg   <= nxt == CHECK_PARITY_ERROR;
    write_enb_reg <= nxt == LOAD_DATA || nxt == LOAD_PARITY || nxt == LOAD_AFTER_FULL;
    busy          <= !(nxt == DECODE_ADDRESS || nxt == LOAD_DATA);
  end

  // Destination address is captured whenever a header is presented during decode
  always_ff @(posedge clk) begin
    if (reset) addr_q <= '0;
    else if (state == DECODE_ADDRESS && pkt_valid) addr_q <= data_in;
  end

endmodule
